// File: rtl/term_collector_if.sv
// Handshake bundle between a sample producer / frame consumer and term_collector.
// The master side is the testbench or surrounding logic; the slave side is the collector.
interface term_collector_if #(
  parameter int in_bits  = 1,
  parameter int in_terms = 1
);
  localparam int fill_w = $clog2(in_terms + 1);

  logic signed [in_bits-1:0] in;
  logic                      in_valid;
  logic                      in_ready;
  logic                      flush;
  logic signed [in_bits-1:0] out [in_terms];
  logic                      out_valid;
  logic                      out_ready;
  logic [fill_w-1:0]         fill;

  modport master (
    output in, in_valid, flush, out_ready,
    input  in_ready, out, out_valid, fill
  );

  modport slave (
    input  in, in_valid, flush, out_ready,
    output in_ready, out, out_valid, fill
  );
endinterface

// File: rtl/term_collector.sv
// Serial-to-parallel frame collector: gathers in_terms signed samples into a collect
// bank and hands complete frames to a separate output bank under valid/ready.
module term_collector #(
  parameter int in_bits  = 1,
  parameter int in_terms = 1
) (
  input  logic             clk,
  input  logic             rst,
  term_collector_if.slave  bus
);
  localparam int fill_w = $clog2(in_terms + 1);
  localparam logic [fill_w-1:0] full_cnt = fill_w'(in_terms);
  localparam logic [fill_w-1:0] zero_cnt = {fill_w{1'b0}};
  localparam logic signed [in_bits-1:0] zero_smp = {in_bits{1'b0}};

  logic [fill_w-1:0]         fill_q, fill_d;
  logic signed [in_bits-1:0] collect_q [in_terms];
  logic signed [in_bits-1:0] collect_d [in_terms];
  logic signed [in_bits-1:0] out_q [in_terms];
  logic signed [in_bits-1:0] out_d [in_terms];
  logic                      out_valid_q, out_valid_d;

  logic              full_s, slot_free_s, xfer_s, in_ready_s, accept_s, flush_s;
  logic [fill_w-1:0] slot_k_s;

  // in_ready deliberately sees out_ready combinationally so a full bank can refill in the transfer cycle.
  assign full_s      = (fill_q == full_cnt);
  assign slot_free_s = !out_valid_q || bus.out_ready;
  assign xfer_s      = full_s && slot_free_s;
  assign in_ready_s  = !full_s || xfer_s;
  assign accept_s    = bus.in_valid && in_ready_s;
  assign flush_s     = bus.flush && !accept_s && (fill_q != zero_cnt) && !full_s;
  assign slot_k_s    = xfer_s ? zero_cnt : fill_q;

  // Next-state for the fill counter, both banks and the output valid flag.
  always_comb begin
    fill_d      = fill_q;
    collect_d   = collect_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;

    if (accept_s) begin
      fill_d = slot_k_s + fill_w'(1);
    end else if (flush_s) begin
      fill_d = full_cnt;
    end else if (xfer_s) begin
      fill_d = zero_cnt;
    end else begin
      fill_d = fill_q;
    end

    for (int i = 0; i < in_terms; i++) begin
      if (accept_s && (fill_w'(i) == slot_k_s)) begin
        collect_d[i] = bus.in;
      end else if (flush_s && (fill_w'(i) >= fill_q)) begin
        collect_d[i] = zero_smp;
      end else begin
        collect_d[i] = collect_q[i];
      end
    end

    // The output bank only changes on transfer; draining just drops valid.
    if (xfer_s) begin
      out_d       = collect_q;
      out_valid_d = 1'b1;
    end else if (out_valid_q && bus.out_ready) begin
      out_d       = out_q;
      out_valid_d = 1'b0;
    end else begin
      out_d       = out_q;
      out_valid_d = out_valid_q;
    end
  end

  // State registers with synchronous reset clearing both banks.
  always_ff @(posedge clk) begin
    if (rst) begin
      fill_q      <= zero_cnt;
      out_valid_q <= 1'b0;
      for (int i = 0; i < in_terms; i++) begin
        collect_q[i] <= zero_smp;
        out_q[i]     <= zero_smp;
      end
    end else begin
      fill_q      <= fill_d;
      out_valid_q <= out_valid_d;
      collect_q   <= collect_d;
      out_q       <= out_d;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out       = out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.fill      = fill_q;
endmodule
